// File: rtl/video_pkg.sv
// Shared video timing defaults, timing struct and total-count helpers.
// FB_SCANOUT_DOUBLE_BUFFER_EN selects two framebuffers (NBUF=2) instead of one.
package video_pkg;

    localparam int unsigned DEF_DISPLAY_WIDTH  = 100;
    localparam int unsigned DEF_DISPLAY_HEIGHT = 100;
    localparam int unsigned DEF_H_FRONT        = 4;
    localparam int unsigned DEF_H_SYNC         = 8;
    localparam int unsigned DEF_H_BACK         = 8;
    localparam int unsigned DEF_V_FRONT        = 2;
    localparam int unsigned DEF_V_SYNC         = 2;
    localparam int unsigned DEF_V_BACK         = 4;
    localparam int unsigned CNT_BITS           = 16;

`ifdef FB_SCANOUT_DOUBLE_BUFFER_EN
    localparam int unsigned NBUF = 2;
`else
    localparam int unsigned NBUF = 1;
`endif

    typedef struct packed {
        logic [CNT_BITS-1:0] h;
        logic [CNT_BITS-1:0] v;
        logic                de;
        logic                hsync;
        logic                vsync;
    } video_timing_t;

    function automatic int unsigned h_total(input int unsigned width, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return width + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned height, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return height + front + sync + back;
    endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port: scanout drives the address, memory returns data one clock later.
interface framebuffer_scanout_if #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned DATA_BITS = 16
);
    logic [ADDR_BITS-1:0] framebuffer_rd_addr;
    logic [DATA_BITS-1:0] framebuffer_rd_data;

    modport master (output framebuffer_rd_addr, input framebuffer_rd_data);
    modport slave  (input framebuffer_rd_addr, output framebuffer_rd_data);
endinterface

// File: rtl/video_timing_gen.sv
// Horizontal/vertical position counters with active-area and sync decode.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
    parameter int unsigned DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
    parameter int unsigned H_FRONT        = DEF_H_FRONT,
    parameter int unsigned H_SYNC         = DEF_H_SYNC,
    parameter int unsigned H_BACK         = DEF_H_BACK,
    parameter int unsigned V_FRONT        = DEF_V_FRONT,
    parameter int unsigned V_SYNC         = DEF_V_SYNC,
    parameter int unsigned V_BACK         = DEF_V_BACK
) (
    input  logic          clk,
    input  logic          rst,
    output video_timing_t timing
);
    localparam int unsigned HT = h_total(DISPLAY_WIDTH, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned VT = v_total(DISPLAY_HEIGHT, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HS_START = DISPLAY_WIDTH + H_FRONT;
    localparam int unsigned VS_START = DISPLAY_HEIGHT + V_FRONT;

    logic [CNT_BITS-1:0] h_q, h_d, v_q, v_d;

    always_comb begin
        h_d = h_q + CNT_BITS'(1);
        v_d = v_q;
        if (h_q == CNT_BITS'(HT - 1)) begin
            h_d = '0;
            v_d = (v_q == CNT_BITS'(VT - 1)) ? '0 : v_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        timing.h     = h_q;
        timing.v     = v_q;
        timing.de    = (h_q < CNT_BITS'(DISPLAY_WIDTH)) && (v_q < CNT_BITS'(DISPLAY_HEIGHT));
        timing.hsync = (h_q >= CNT_BITS'(HS_START)) && (h_q < CNT_BITS'(HS_START + H_SYNC));
        timing.vsync = (v_q >= CNT_BITS'(VS_START)) && (v_q < CNT_BITS'(VS_START + V_SYNC));
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: addressing, one-clock output pipeline and front/back buffer swap.
// Define FB_SCANOUT_DOUBLE_BUFFER_EN for double buffering; otherwise buffer 0 is always scanned.
module framebuffer_scanout
    import video_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH         = DEF_DISPLAY_WIDTH,
    parameter int unsigned DISPLAY_HEIGHT        = DEF_DISPLAY_HEIGHT,
    parameter int unsigned H_FRONT               = DEF_H_FRONT,
    parameter int unsigned H_SYNC                = DEF_H_SYNC,
    parameter int unsigned H_BACK                = DEF_H_BACK,
    parameter int unsigned V_FRONT               = DEF_V_FRONT,
    parameter int unsigned V_SYNC                = DEF_V_SYNC,
    parameter int unsigned V_BACK                = DEF_V_BACK,
    parameter int unsigned FRAMEBUFFER_DATA_BITS = 16,
    parameter int unsigned FRAMEBUFFER_ADDR_BITS = $clog2(NBUF * DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
    input  logic                             clk,
    input  logic                             rst,
    framebuffer_scanout_if.master            fb,
    output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data,
    output logic                             pixel_de,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             frame_start,
    input  logic                             swap_req,
    output logic                             swap_ack,
    output logic                             front_buf
);
    localparam int unsigned FRAME_PIXELS = DISPLAY_WIDTH * DISPLAY_HEIGHT;

    video_timing_t timing;

    video_timing_gen #(
        .DISPLAY_WIDTH (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
        .H_FRONT       (H_FRONT),
        .H_SYNC        (H_SYNC),
        .H_BACK        (H_BACK),
        .V_FRONT       (V_FRONT),
        .V_SYNC        (V_SYNC),
        .V_BACK        (V_BACK)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .timing(timing)
    );

    logic [FRAMEBUFFER_ADDR_BITS-1:0] addr_q, addr_live, addr_out;
    logic de_q, hsync_q, vsync_q, frame_start_q, swap_ack_q;
    logic front_buf_q, front_buf_d;
    logic swap_take;

    // Swap only at the first clock of vertical blanking, so active lines never see a change.
    assign swap_take = swap_req && (timing.h == '0) && (timing.v == CNT_BITS'(DISPLAY_HEIGHT));

`ifdef FB_SCANOUT_DOUBLE_BUFFER_EN
    assign front_buf_d = swap_take ? ~front_buf_q : front_buf_q;
    assign addr_live   = FRAMEBUFFER_ADDR_BITS'(32'(timing.h)
                         + 32'(DISPLAY_WIDTH) * 32'(timing.v)
                         + (front_buf_q ? 32'(FRAME_PIXELS) : 32'd0));
`else
    assign front_buf_d = 1'b0;
    assign addr_live   = FRAMEBUFFER_ADDR_BITS'(32'(timing.h)
                         + 32'(DISPLAY_WIDTH) * 32'(timing.v));
`endif

    // Address is live during the active area and holds the last issued value in blanking.
    assign addr_out = timing.de ? addr_live : addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q        <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            front_buf_q   <= 1'b0;
        end else begin
            addr_q        <= addr_out;
            de_q          <= timing.de;
            hsync_q       <= timing.hsync;
            vsync_q       <= timing.vsync;
            frame_start_q <= (timing.h == '0) && (timing.v == '0);
            swap_ack_q    <= swap_take;
            front_buf_q   <= front_buf_d;
        end
    end

    assign fb.framebuffer_rd_addr = addr_out;
    assign pixel_data  = de_q ? fb.framebuffer_rd_data : '0;
    assign pixel_de    = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign swap_ack    = swap_ack_q;
    assign front_buf   = front_buf_q;

endmodule
